// File: rtl/serial_rx_sequencer_if.sv
// Host/receiver signal bundle for serial_rx_sequencer.
// slave  : the sequencer's view (config, receiver status and host pop in; receiver control and FIFO head out).
// master : the driving side's view (host plus receiver), directions mirrored.
interface serial_rx_sequencer_if #(
    parameter int BAUD_W = 32
);
    logic [BAUD_W-1:0] baud_i;
    logic [1:0]        dbits_i;
    logic              stop2_i;
    logic              par_en_i;
    logic              par_odd_i;
    logic              rx_idle_i;
    logic [63:0]       rx_dat_i;
    logic              rx_reset_o;
    logic [5:0]        rx_bits_o;
    logic [BAUD_W-1:0] rx_baud_o;
    logic [7:0]        dat_o;
    logic [2:0]        err_o;
    logic              valid_o;
    logic              ready_i;
    logic              overrun_o;
    logic              clr_i;

    modport slave (
        input  baud_i, dbits_i, stop2_i, par_en_i, par_odd_i, rx_idle_i, rx_dat_i, ready_i, clr_i,
        output rx_reset_o, rx_bits_o, rx_baud_o, dat_o, err_o, valid_o, overrun_o
    );

    modport master (
        output baud_i, dbits_i, stop2_i, par_en_i, par_odd_i, rx_idle_i, rx_dat_i, ready_i, clr_i,
        input  rx_reset_o, rx_bits_o, rx_baud_o, dat_o, err_o, valid_o, overrun_o
    );
endinterface

// File: rtl/serial_rx_sequencer.sv
// serial_rx_sequencer: arms a 64-bit MSB-in serial receiver, waits for each frame,
// decodes start/data/parity/stop and queues {brk, par, frm, data} in a show-ahead FIFO.
// Optional feature macro: SERIAL_RX_PARITY_EN (parity bit in the frame and the par flag).
module serial_rx_sequencer #(
    parameter int DEPTH_LOG2 = 2,
    parameter int BAUD_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    serial_rx_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = 11;

    typedef enum logic [1:0] {ST_ARM, ST_WAIT, ST_BUSY, ST_CAP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          dbits_q;
    logic                stop2_q;
    logic [5:0]          bits_q;
    logic [BAUD_W-1:0]   baud_q;
    logic                par_en_in;
    logic [63:0]         frame_p0;
    logic [63:0]         frame_al;
    logic [ENT_W-1:0]    entry;
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [ENT_W-1:0]    last_q;
    logic                overrun_q;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                accept;
    logic                drop;

    // Right-align the N frame bits so that f[0] is the start bit; the rest of the shift register is masked off.
    function automatic logic [63:0] align_frame(input logic [63:0] raw, input logic [5:0] n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return (raw >> (7'd64 - {1'b0, n})) & mask;
    endfunction

    // Data bits follow the start bit LSB first; unused upper bits read as zero.
    function automatic logic [7:0] data_field(input logic [63:0] f, input logic [1:0] dbits);
        logic [7:0] keep;
        keep = 8'hFF >> (2'd3 - dbits);
        return f[8:1] & keep;
    endfunction

    // Stop bits always occupy the top of the frame, so they are located from N rather than from D/P.
    function automatic logic [ENT_W-1:0] decode_frame(input logic [63:0] f, input logic [5:0] n,
                                                      input logic [1:0] dbits, input logic stop2);
        logic frm;
        logic brk;
        frm = f[0] | ~f[n - 6'd1] | (stop2 & ~f[n - 6'd2]);
        brk = (f == 64'd0);
        return {brk, 1'b0, frm, data_field(f, dbits)};
    endfunction

`ifdef SERIAL_RX_PARITY_EN
    logic par_en_q;
    logic par_odd_q;

    // Parity sits directly after the last data bit, at f[D+1] = f[6 + dbits].
    function automatic logic parity_bad(input logic [63:0] f, input logic [1:0] dbits, input logic odd);
        logic [5:0] pidx;
        pidx = 6'd6 + {4'd0, dbits};
        return f[pidx] != ((^data_field(f, dbits)) ^ odd);
    endfunction

    // Parity options are latched together with the rest of the frame format at re-arm.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (state == ST_ARM) begin
            par_en_q  <= bus.par_en_i;
            par_odd_q <= bus.par_odd_i;
        end
    end

    assign par_en_in = bus.par_en_i;
`else
    assign par_en_in = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= ST_ARM;
        else         state <= state_nxt;
    end

    // Next state: ARM lasts one cycle, then follow the receiver's idle flag around one frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARM:  state_nxt = ST_WAIT;
            ST_WAIT: if (!bus.rx_idle_i) state_nxt = ST_BUSY;
            ST_BUSY: if (bus.rx_idle_i)  state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_ARM;
            default: state_nxt = ST_ARM;
        endcase
    end

    // FSM outputs: receiver reset is held through sequencer reset and pulsed once per re-arm.
    always_comb begin
        bus.rx_reset_o = reset_i | (state == ST_ARM);
        push           = (state == ST_CAP);
    end

    // Frame format latched at re-arm so host-side changes never disturb a frame in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bits_q  <= 6'd10;
            baud_q  <= '0;
            dbits_q <= 2'd3;
            stop2_q <= 1'b0;
        end else if (state == ST_ARM) begin
            dbits_q <= bus.dbits_i;
            stop2_q <= bus.stop2_i;
            baud_q  <= bus.baud_i;
            bits_q  <= 6'd7 + {4'd0, bus.dbits_i} + {5'd0, par_en_in} + {5'd0, bus.stop2_i};
        end
    end

    assign bus.rx_bits_o = bits_q;
    assign bus.rx_baud_o = baud_q;

    // ---- stage p0: snapshot of the receiver shift register on the cycle the frame completes
    always_ff @(posedge clk_i) begin
        if ((state == ST_BUSY) && bus.rx_idle_i) frame_p0 <= bus.rx_dat_i;
    end

    assign frame_al = align_frame(frame_p0, bits_q);

    // Decode the captured frame into the FIFO entry {brk, par, frm, data}.
    always_comb begin
        entry = decode_frame(frame_al, bits_q, dbits_q, stop2_q);
`ifdef SERIAL_RX_PARITY_EN
        entry[9] = par_en_q & parity_bad(frame_al, dbits_q, par_odd_q);
`endif
    end

    // FIFO status and show-ahead head; a pop in the same cycle frees the slot for a push when full.
    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
        pop    = ~empty & bus.ready_i;
        accept = push & (~full | pop);
        drop   = push & full & ~pop;
        bus.valid_o   = ~empty;
        bus.overrun_o = overrun_q;
        {bus.err_o, bus.dat_o} = empty ? last_q : mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    // FIFO storage (data only, never reset).
    always_ff @(posedge clk_i) begin
        if (accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= entry;
    end

    // FIFO pointers, last-popped hold value and sticky overrun (set beats clear).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            if (drop)            overrun_q <= 1'b1;
            else if (bus.clr_i)  overrun_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Self-checking bench for serial_rx_sequencer: the bench plays both host and receiver,
// builds frames field by field and predicts FIFO contents with a queue model.
module tb_serial_rx_sequencer;
    localparam int DEPTH_LOG2 = 1;
    localparam int DEPTH      = 2;
    localparam int BAUD_W     = 32;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] baud;
        logic [1:0]  dbits;
        logic        stop2;
        logic        par_en;
        logic        par_odd;
    } cfg_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    serial_rx_sequencer_if #(.BAUD_W(BAUD_W)) bus ();

    serial_rx_sequencer #(.DEPTH_LOG2(DEPTH_LOG2), .BAUD_W(BAUD_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [10:0] model_q[$];
    bit          ovr_exp  = 1'b0;
    logic [10:0] last_exp = '0;
    cfg_t        cur_cfg;

    function automatic cfg_t mk_cfg(input logic [1:0] dbits, input bit stop2, input bit pen, input bit podd);
        cfg_t c;
        c.baud = $urandom; c.dbits = dbits; c.stop2 = stop2; c.par_en = pen; c.par_odd = podd;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        return mk_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // Frame length = start + data + optional parity + one or two stop bits.
    function automatic int nbits(input cfg_t c);
        return 1 + (5 + int'(c.dbits)) + ((PAR_BUILD && c.par_en) ? 1 : 0) + (c.stop2 ? 2 : 1);
    endfunction

    // Lay the frame out as the receiver would hold it and predict the decoded entry.
    function automatic void build(input cfg_t c, input logic [7:0] data, input bit start, input bit pbit,
                                  input bit s1, input bit s2, output logic [63:0] raw, output logic [10:0] ent);
        logic [11:0] f;
        logic [7:0]  dm;
        int d, n, k;
        bit p, frm, par, brk;
        d = 5 + int'(c.dbits);
        p = PAR_BUILD && c.par_en;
        n = nbits(c);
        dm = data & 8'((1 << d) - 1);
        f = '0;
        f[0] = start;
        for (int i = 0; i < d; i++) f[1 + i] = dm[i];
        k = 1 + d;
        if (p) begin f[k] = pbit; k++; end
        f[k] = s1; k++;
        if (c.stop2) f[k] = s2;
        raw = {$urandom, $urandom};
        for (int i = 0; i < n; i++) raw[64 - n + i] = f[i];
        frm = start || !s1 || (c.stop2 && !s2);
        par = p && (pbit != ((^dm) ^ c.par_odd));
        brk = (f == 12'd0);
        ent = {brk, par, frm, dm};
    endfunction

    task automatic apply_cfg(input cfg_t c);
        bus.baud_i = c.baud; bus.dbits_i = c.dbits; bus.stop2_i = c.stop2;
        bus.par_en_i = c.par_en; bus.par_odd_i = c.par_odd;
    endtask

    task automatic apply_reset(input string name, input cfg_t c);
        @(posedge clk); #1;
        reset = 1'b1; bus.rx_idle_i = 1'b1; bus.ready_i = 1'b0; bus.clr_i = 1'b0;
        apply_cfg(c);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b1) $display("FAIL %s rx_reset_in_reset got %b want 1", name, bus.rx_reset_o); else n_pass++;
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL %s valid_in_reset got %b want 0", name, bus.valid_o); else n_pass++;
        n_checks++; if (bus.overrun_o !== 1'b0) $display("FAIL %s overrun_in_reset got %b want 0", name, bus.overrun_o); else n_pass++;
        n_checks++; if ({bus.err_o, bus.dat_o} !== 11'h000) $display("FAIL %s head_in_reset got %h want 000", name, {bus.err_o, bus.dat_o}); else n_pass++;
        n_checks++; if (bus.rx_bits_o !== 6'd10) $display("FAIL %s bits_in_reset got %0d want 10", name, bus.rx_bits_o); else n_pass++;
        n_checks++; if (bus.rx_baud_o !== '0) $display("FAIL %s baud_in_reset got %h want 0", name, bus.rx_baud_o); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b1) $display("FAIL %s rearm_pulse got %b want 1", name, bus.rx_reset_o); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b0) $display("FAIL %s rearm_end got %b want 0", name, bus.rx_reset_o); else n_pass++;
        n_checks++; if (int'(bus.rx_bits_o) !== nbits(c)) $display("FAIL %s bits_after_arm got %0d want %0d", name, bus.rx_bits_o, nbits(c)); else n_pass++;
        n_checks++; if (bus.rx_baud_o !== c.baud) $display("FAIL %s baud_after_arm got %h want %h", name, bus.rx_baud_o, c.baud); else n_pass++;
        model_q.delete(); ovr_exp = 1'b0; last_exp = '0; cur_cfg = c;
    endtask

    // One frame as seen from the receiver: start bit, a few busy cycles, then idle with the frame loaded.
    task automatic run_frame(input string name, input logic [63:0] raw, input logic [10:0] ent,
                             input cfg_t nxt, input bit rdy_cap, input bit clr_cap);
        bit popped;
        @(posedge clk); #1;
        bus.rx_idle_i = 1'b0;
        apply_cfg(rand_cfg());
        bus.rx_dat_i = {$urandom, $urandom};
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.rx_dat_i = raw; bus.rx_idle_i = 1'b1;
        apply_cfg(nxt);
        @(posedge clk); #1;
        bus.ready_i = rdy_cap; bus.clr_i = clr_cap;
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b0) $display("FAIL %s rx_reset_during_cap got %b want 0", name, bus.rx_reset_o); else n_pass++;
        @(posedge clk); #1;
        bus.ready_i = 1'b0; bus.clr_i = 1'b0;
        popped = rdy_cap && (model_q.size() != 0);
        if (popped) last_exp = model_q.pop_front();
        if (model_q.size() == DEPTH) ovr_exp = 1'b1;
        else begin
            model_q.push_back(ent);
            if (clr_cap) ovr_exp = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b1) $display("FAIL %s rearm_pulse got %b want 1", name, bus.rx_reset_o); else n_pass++;
        n_checks++; if (bus.valid_o !== (model_q.size() != 0)) $display("FAIL %s valid got %b want %b", name, bus.valid_o, model_q.size() != 0); else n_pass++;
        if (model_q.size() != 0) begin
            n_checks++; if ({bus.err_o, bus.dat_o} !== model_q[0]) $display("FAIL %s head got %h want %h", name, {bus.err_o, bus.dat_o}, model_q[0]); else n_pass++;
        end
        n_checks++; if (bus.overrun_o !== ovr_exp) $display("FAIL %s overrun got %b want %b", name, bus.overrun_o, ovr_exp); else n_pass++;
        @(posedge clk);
        cur_cfg = nxt;
        @(negedge clk);
        n_checks++; if (bus.rx_reset_o !== 1'b0) $display("FAIL %s rearm_end got %b want 0", name, bus.rx_reset_o); else n_pass++;
        n_checks++; if (int'(bus.rx_bits_o) !== nbits(nxt)) $display("FAIL %s next_bits got %0d want %0d", name, bus.rx_bits_o, nbits(nxt)); else n_pass++;
        n_checks++; if (bus.rx_baud_o !== nxt.baud) $display("FAIL %s next_baud got %h want %h", name, bus.rx_baud_o, nxt.baud); else n_pass++;
    endtask

    task automatic pop_one(input string name);
        logic [10:0] e;
        @(negedge clk);
        e = model_q.pop_front();
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL %s pop_valid got %b want 1", name, bus.valid_o); else n_pass++;
        n_checks++; if ({bus.err_o, bus.dat_o} !== e) $display("FAIL %s pop_head got %h want %h", name, {bus.err_o, bus.dat_o}, e); else n_pass++;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        last_exp = e;
    endtask

    task automatic expect_empty(input string name);
        @(negedge clk);
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL %s empty_valid got %b want 0", name, bus.valid_o); else n_pass++;
        n_checks++; if ({bus.err_o, bus.dat_o} !== last_exp) $display("FAIL %s hold_last got %h want %h", name, {bus.err_o, bus.dat_o}, last_exp); else n_pass++;
    endtask

    task automatic clear_overrun(input string name);
        @(negedge clk);
        bus.clr_i = 1'b1;
        @(posedge clk); #1;
        bus.clr_i = 1'b0;
        ovr_exp = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.overrun_o !== 1'b0) $display("FAIL %s overrun_clr got %b want 0", name, bus.overrun_o); else n_pass++;
    endtask

    task automatic send(input string name, input logic [7:0] data, input bit start, input bit pbit,
                        input bit s1, input bit s2, input cfg_t nxt, input bit rdy_cap, input bit clr_cap);
        logic [63:0] raw;
        logic [10:0] ent;
        build(cur_cfg, data, start, pbit, s1, s2, raw, ent);
        run_frame(name, raw, ent, nxt, rdy_cap, clr_cap);
    endtask

    task automatic test_reset();
        apply_reset("reset", mk_cfg(2'd3, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic test_8n1();
        send("8n1_55", 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, mk_cfg(2'd3, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        pop_one("8n1_55");
        expect_empty("8n1_55");
    endtask

    task automatic test_parity();
        send("8o1_bad", 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, mk_cfg(2'd3, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        pop_one("8o1_bad");
        send("8o1_good", 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, mk_cfg(2'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
        pop_one("8o1_good");
    endtask

    task automatic test_5n2();
        send("5n2_stop", 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0, mk_cfg(2'd3, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        pop_one("5n2_stop");
    endtask

    task automatic test_break();
        send("break", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk_cfg(2'd3, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        pop_one("break");
        expect_empty("break");
    endtask

    task automatic test_overrun();
        cfg_t c;
        c = mk_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send("ovr_1", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        send("ovr_2", 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        send("ovr_3", 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        pop_one("ovr_pop1");
        pop_one("ovr_pop2");
        expect_empty("ovr_drain");
        clear_overrun("ovr_clr");
    endtask

    task automatic test_full_push_pop();
        cfg_t c;
        c = mk_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send("fpp_1", 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        send("fpp_2", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        send("fpp_pop", 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b1, 1'b0);
        send("fpp_setwins", 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b1);
        pop_one("fpp_pop22");
        pop_one("fpp_pop33");
        expect_empty("fpp_drain");
        clear_overrun("fpp_clr");
    endtask

    task automatic test_reset_mid_frame();
        cfg_t c;
        c = mk_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send("mid_pre", 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.rx_idle_i = 1'b0;
        repeat (4) @(posedge clk);
        apply_reset("mid_reset", c);
        send("mid_a5", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        pop_one("mid_a5");
        expect_empty("mid_a5");
    endtask

    task automatic test_random();
        logic [7:0] data;
        bit start, pbit, s1, s2;
        int npop;
        for (int it = 0; it < 80; it++) begin
            data  = 8'($urandom);
            start = ($urandom_range(0, 5) == 0);
            s1    = ($urandom_range(0, 5) != 0);
            s2    = ($urandom_range(0, 5) != 0);
            pbit  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                data = 8'h00; start = 1'b0; pbit = 1'b0; s1 = 1'b0; s2 = 1'b0;
            end
            send("random", data, start, pbit, s1, s2, rand_cfg(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            npop = $urandom_range(0, model_q.size());
            for (int k = 0; k < npop; k++) pop_one("random_pop");
            if (model_q.size() == 0 && $urandom_range(0, 1) == 1) expect_empty("random_empty");
        end
        while (model_q.size() != 0) pop_one("random_drain");
        expect_empty("random_drain");
        clear_overrun("random_clr");
    endtask

    initial begin
        bus.baud_i = '0; bus.dbits_i = 2'd3; bus.stop2_i = 1'b0; bus.par_en_i = 1'b0; bus.par_odd_i = 1'b0;
        bus.rx_idle_i = 1'b1; bus.rx_dat_i = '0; bus.ready_i = 1'b0; bus.clr_i = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_5n2();
        test_break();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
